capture_buffer_ctrl: RTL and testbench

- Parametrised capture buffer for the DSP chain.
- Stores a stream of filter-output samples into an internal inferred dual-port RAM under control of a state machine.
- Supports single-shot and pre-trigger (circular) capture modes, sample decimation, and an ordered read-out port that returns samples oldest-first.
- Sits between the filter output and the debug/read-out logic; replaces the fixed-size counter-plus-FSM capture path.

---
 rtl/capture_buffer_ctrl.sv | 172 +++++++++++++++++
 tb/tb_capture_buffer_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_buffer_ctrl.sv
// Capture buffer controller: decimated sample capture into an inferred dual-port RAM,
// single-shot or pre-trigger (circular) mode, with an oldest-first read-out port.
module capture_buffer_ctrl #(
    parameter int NB_DATA  = 14,
    parameter int NB_ADDR  = 11,
    parameter int NB_DECIM = 4
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic                i_valid,
    input  logic                i_mode,
    input  logic                i_start,
    input  logic [NB_DECIM-1:0] i_decim,
    input  logic [NB_ADDR-1:0]  i_post_count,
    input  logic                i_abort,
    input  logic                i_rd_en,
    output logic [NB_DATA-1:0]  o_rd_data,
    output logic                o_rd_valid,
    output logic                o_rd_last,
    output logic                o_busy,
    output logic                o_full,
    output logic [NB_ADDR-1:0]  o_trig_addr,
    output logic [1:0]          o_state
);

    localparam int DEPTH = 2 ** NB_ADDR;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t state, state_next;

    logic                start_q;
    logic                start_evt;
    logic                mode_q;
    logic [NB_DECIM-1:0] decim_q;
    logic [NB_DECIM-1:0] dec_cnt;
    logic [NB_ADDR-1:0]  wr_ptr;
    logic                wrapped;
    logic [NB_ADDR-1:0]  post_cnt;
    logic [NB_ADDR-1:0]  trig_addr;
    logic                capturing;
    logic                wr_stb;
    logic [NB_ADDR:0]    rd_cnt;
    logic [NB_ADDR:0]    rd_total;
    logic [NB_ADDR-1:0]  rd_addr;
    logic                rd_req;
    logic                last_req;
    logic                rd_valid_q;
    logic                rd_last_q;
    logic [NB_DATA-1:0]  rd_data_q;
    logic [NB_DATA-1:0]  ram [DEPTH];

    assign start_evt = i_start & ~start_q;
    assign capturing = (state == ST_ARMED) || (state == ST_CAPTURE);
    assign wr_stb    = capturing & i_valid & (dec_cnt == '0) & ~i_abort;

    // Read handshake: i_rd_en is a request with no backpressure; each accepted request
    // returns exactly one sample on o_rd_data with o_rd_valid high one cycle later.
    // Write side is frozen in DONE, so the read window derives directly from wr_ptr/wrapped.
    assign rd_total = wrapped ? {1'b1, {NB_ADDR{1'b0}}} : {1'b0, wr_ptr};
    assign rd_addr  = (wrapped ? wr_ptr : '0) + rd_cnt[NB_ADDR-1:0];
    assign rd_req   = (state == ST_DONE) & i_rd_en & (rd_cnt < rd_total) & ~i_abort;
    assign last_req = rd_req & (rd_cnt == rd_total - 1'b1);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_evt) state_next = i_mode ? ST_ARMED : ST_CAPTURE;
            end
            ST_ARMED: begin
                if (start_evt) state_next = (i_post_count == '0) ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (wr_stb) begin
                    if (!mode_q) begin
                        if (wr_ptr == {NB_ADDR{1'b1}}) state_next = ST_DONE;
                    end else if (post_cnt <= NB_ADDR'(1)) begin
                        state_next = ST_DONE;
                    end
                end else if (mode_q && (post_cnt == '0)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if ((rd_total == '0) || rd_last_q) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (i_abort) state_next = ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state      <= ST_IDLE;
            start_q    <= 1'b0;
            mode_q     <= 1'b0;
            decim_q    <= '0;
            dec_cnt    <= '0;
            wr_ptr     <= '0;
            wrapped    <= 1'b0;
            post_cnt   <= '0;
            trig_addr  <= '0;
            rd_cnt     <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state      <= state_next;
            start_q    <= i_start;
            rd_valid_q <= rd_req;
            rd_last_q  <= last_req;
            if (rd_req) begin
                rd_data_q <= ram[rd_addr];
                rd_cnt    <= rd_cnt + 1'b1;
            end
            if (i_abort) begin
                trig_addr <= '0;
                rd_data_q <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        wr_ptr   <= '0;
                        dec_cnt  <= '0;
                        wrapped  <= 1'b0;
                        rd_cnt   <= '0;
                        post_cnt <= '0;
                        if (start_evt) begin
                            mode_q    <= i_mode;
                            decim_q   <= i_decim;
                            trig_addr <= '0;
                        end
                    end
                    ST_ARMED, ST_CAPTURE: begin
                        if (i_valid) dec_cnt <= (dec_cnt == '0) ? decim_q : dec_cnt - 1'b1;
                        if (wr_stb) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (wr_ptr == {NB_ADDR{1'b1}}) wrapped <= 1'b1;
                        end
                        // i_post_count is NB_ADDR wide, so it never exceeds DEPTH-1.
                        if ((state == ST_ARMED) && start_evt) begin
                            trig_addr <= wr_ptr;
                            post_cnt  <= i_post_count;
                        end else if ((state == ST_CAPTURE) && mode_q && wr_stb && (post_cnt != '0)) begin
                            post_cnt <= post_cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset && wr_stb) ram[wr_ptr] <= i_data;
    end

    assign o_rd_data   = rd_data_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_last   = rd_last_q;
    assign o_busy      = capturing;
    assign o_full      = (state == ST_DONE);
    assign o_trig_addr = trig_addr;
    assign o_state     = state;

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// Bench for capture_buffer_ctrl: directed ramp scenarios plus randomized captures,
// checked against a queue-based behavioural model of the capture buffer.
module tb_capture_buffer_ctrl;

    localparam int NB_DATA  = 14;
    localparam int NB_ADDR  = 4;
    localparam int NB_DECIM = 4;
    localparam int DEPTH    = 16;
    localparam int PH_IDLE = 0, PH_ARMED = 1, PH_CAPTURE = 2, PH_DONE = 3;

    logic                clock = 1'b0;
    logic                i_reset = 1'b0;
    logic [NB_DATA-1:0]  i_data = '0;
    logic                i_valid = 1'b0;
    logic                i_mode = 1'b0;
    logic                i_start = 1'b0;
    logic [NB_DECIM-1:0] i_decim = '0;
    logic [NB_ADDR-1:0]  i_post_count = '0;
    logic                i_abort = 1'b0;
    logic                i_rd_en = 1'b0;
    logic [NB_DATA-1:0]  o_rd_data;
    logic                o_rd_valid;
    logic                o_rd_last;
    logic                o_busy;
    logic                o_full;
    logic [NB_ADDR-1:0]  o_trig_addr;
    logic [1:0]          o_state;

    always #5 clock = ~clock;

    capture_buffer_ctrl #(
        .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_DECIM(NB_DECIM)
    ) dut (
        .clock(clock), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
        .i_mode(i_mode), .i_start(i_start), .i_decim(i_decim),
        .i_post_count(i_post_count), .i_abort(i_abort), .i_rd_en(i_rd_en),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_last(o_rd_last),
        .o_busy(o_busy), .o_full(o_full), .o_trig_addr(o_trig_addr), .o_state(o_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ctl_diff, busy_cycles, stray, last_cnt, last_pos, ramp;
    logic [NB_DATA-1:0] exp_q[$];
    logic [NB_DATA-1:0] got_q[$];

    // Behavioural model: the buffer is a queue of the most recent DEPTH stored samples.
    int                 m_phase = PH_IDLE;
    bit                 m_start_prev, m_mode, m_busy, m_full, m_rd_valid, m_rd_last;
    int                 m_decim, m_skip, m_stores, m_post_left, m_reads;
    logic [NB_DATA-1:0] m_buf[$];
    logic [NB_DATA-1:0] m_rd_data = '0;
    logic [NB_ADDR-1:0] m_trig = '0;

    function automatic void model_step();
        bit evt, stored, prev_last;
        int nxt;
        evt       = i_start && !m_start_prev;
        prev_last = m_rd_last;
        m_rd_valid = 1'b0;
        m_rd_last  = 1'b0;
        if (!i_reset) begin
            m_start_prev = 1'b0;
            m_phase      = PH_IDLE;
            m_trig       = '0;
            m_rd_data    = '0;
        end else begin
            m_start_prev = i_start;
            if (i_abort) begin
                m_phase   = PH_IDLE;
                m_trig    = '0;
                m_rd_data = '0;
            end else begin
                case (m_phase)
                    PH_IDLE: if (evt) begin
                        m_mode = i_mode; m_decim = int'(i_decim); m_skip = 0;
                        m_stores = 0; m_reads = 0; m_buf.delete(); m_trig = '0;
                        m_phase = i_mode ? PH_ARMED : PH_CAPTURE;
                    end
                    PH_ARMED, PH_CAPTURE: begin
                        stored = 1'b0;
                        nxt    = m_phase;
                        if (i_valid) begin
                            if (m_skip == 0) begin stored = 1'b1; m_skip = m_decim; end
                            else m_skip--;
                        end
                        if (m_phase == PH_ARMED && evt) begin
                            m_trig      = m_stores[NB_ADDR-1:0];
                            m_post_left = int'(i_post_count);
                            nxt = (m_post_left == 0) ? PH_DONE : PH_CAPTURE;
                        end else if (m_phase == PH_CAPTURE && stored) begin
                            if (!m_mode) begin
                                if (m_stores + 1 == DEPTH) nxt = PH_DONE;
                            end else begin
                                m_post_left--;
                                if (m_post_left == 0) nxt = PH_DONE;
                            end
                        end
                        if (stored) begin
                            m_buf.push_back(i_data);
                            if (m_buf.size() > DEPTH) void'(m_buf.pop_front());
                            m_stores++;
                        end
                        m_phase = nxt;
                    end
                    default: begin
                        if (m_buf.size() == 0 || prev_last) m_phase = PH_IDLE;
                        else if (i_rd_en && m_reads < m_buf.size()) begin
                            m_rd_valid = 1'b1;
                            m_rd_data  = m_buf[m_reads];
                            m_rd_last  = (m_reads == m_buf.size() - 1);
                            exp_q.push_back(m_rd_data);
                            m_reads++;
                        end
                    end
                endcase
            end
        end
        m_busy = (m_phase == PH_ARMED) || (m_phase == PH_CAPTURE);
        m_full = (m_phase == PH_DONE);
    endfunction

    // One clock: model consumes the inputs, DUT outputs are sampled 1 ns after the edge.
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        if (o_busy === 1'b1) busy_cycles++;
        if (o_rd_valid === 1'b1) begin
            got_q.push_back(o_rd_data);
            if (o_full !== 1'b1) stray++;
            if (o_rd_last === 1'b1) begin last_cnt++; last_pos = got_q.size(); end
        end
        if (o_busy !== m_busy || o_full !== m_full || o_rd_valid !== m_rd_valid ||
            o_rd_last !== m_rd_last || o_rd_data !== m_rd_data || o_trig_addr !== m_trig)
            ctl_diff++;
        @(negedge clock);
    endtask

    task automatic idle_in();
        i_valid = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_rd_en = 1'b0; i_data = '0;
    endtask

    task automatic begin_test();
        got_q.delete(); exp_q.delete();
        ctl_diff = 0; busy_cycles = 0; stray = 0; last_cnt = 0; last_pos = 0; ramp = 0;
        idle_in();
        tick();
    endtask

    task automatic start_capture(input bit mode, input int decim, input int post);
        i_mode = mode; i_decim = NB_DECIM'(decim); i_post_count = NB_ADDR'(post);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic capture_ramp(input int budget, output bit timed_out);
        int n = 0;
        i_valid = 1'b1;
        while (o_full !== 1'b1 && n < budget) begin
            i_data = NB_DATA'(ramp); tick(); ramp++; n++;
        end
        i_valid = 1'b0;
        timed_out = (o_full !== 1'b1);
    endtask

    task automatic read_n(input int n);
        i_valid = 1'b0; i_rd_en = 1'b1;
        repeat (n) tick();
        i_rd_en = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_common(input string tag, input int exp_len);
        n_checks++;
        if (got_q.size() !== exp_len) begin
            n_errors++; $display("FAIL %s_len got %0d want %0d", tag, got_q.size(), exp_len);
        end
        n_checks++;
        if (got_q != exp_q) begin
            n_errors++; $display("FAIL %s_model read-out differs from model (%0d vs %0d samples)", tag, got_q.size(), exp_q.size());
        end
        n_checks++;
        if (ctl_diff !== 0) begin
            n_errors++; $display("FAIL %s_ctl %0d cycles differ from model, want 0", tag, ctl_diff);
        end
        n_checks++;
        if (stray !== 0) begin
            n_errors++; $display("FAIL %s_stray %0d valid pulses outside DONE, want 0", tag, stray);
        end
    endtask

    task automatic test_reset();
        begin_test();
        i_reset = 1'b0; i_start = 1'b1; i_valid = 1'b1; i_rd_en = 1'b1; i_mode = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({o_busy, o_full, o_rd_valid, o_rd_last} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_flags got %b want 0000", {o_busy, o_full, o_rd_valid, o_rd_last});
        end
        n_checks++;
        if (o_rd_data !== '0 || o_trig_addr !== '0) begin
            n_errors++; $display("FAIL reset_data rd_data=%0d trig=%0d want 0/0", o_rd_data, o_trig_addr);
        end
        idle_in();
        i_reset = 1'b1;
        tick();
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_release busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_single_shot();
        bit to;
        begin_test();
        start_capture(1'b0, 0, 0);
        capture_ramp(100, to);
        n_checks++;
        if (to !== 1'b0) begin n_errors++; $display("FAIL t1_timeout full=%b want 1", o_full); end
        n_checks++;
        if (busy_cycles !== 16) begin n_errors++; $display("FAIL t1_busy got %0d cycles want 16", busy_cycles); end
        read_n(16);
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== NB_DATA'(i)) begin n_errors++; $display("FAIL t1_data[%0d] got %0d want %0d", i, got_q[i], i); end
        end
        n_checks++;
        if (last_cnt !== 1 || last_pos !== 16) begin
            n_errors++; $display("FAIL t1_last count %0d pos %0d want 1/16", last_cnt, last_pos);
        end
        n_checks++;
        if (o_full !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++; $display("FAIL t1_idle full=%b busy=%b want 0/0", o_full, o_busy);
        end
        check_common("t1", 16);
    endtask

    task automatic test_decimation();
        bit to;
        begin_test();
        start_capture(1'b0, 2, 0);
        capture_ramp(200, to);
        n_checks++;
        if (to !== 1'b0) begin n_errors++; $display("FAIL t2_timeout full=%b want 1", o_full); end
        read_n(16);
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== NB_DATA'(3 * i)) begin n_errors++; $display("FAIL t2_data[%0d] got %0d want %0d", i, got_q[i], 3 * i); end
        end
        check_common("t2", 16);
    endtask

    task automatic test_pretrigger(input int trig_val, input int post, input int exp_len,
                                   input int first, input int exp_trig, input string tag);
        int n = 0;
        begin_test();
        start_capture(1'b1, 0, post);
        i_valid = 1'b1;
        while (o_full !== 1'b1 && n < 200) begin
            i_data = NB_DATA'(ramp); i_start = (ramp == trig_val); tick(); ramp++; n++;
        end
        i_start = 1'b0;
        n_checks++;
        if (o_full !== 1'b1) begin n_errors++; $display("FAIL %s_timeout full=%b want 1", tag, o_full); end
        n_checks++;
        if (o_trig_addr !== NB_ADDR'(exp_trig)) begin
            n_errors++; $display("FAIL %s_trig got %0d want %0d", tag, o_trig_addr, exp_trig);
        end
        read_n(exp_len + 3);
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== NB_DATA'(first + i)) begin n_errors++; $display("FAIL %s_data[%0d] got %0d want %0d", tag, i, got_q[i], first + i); end
        end
        n_checks++;
        if (last_cnt !== 1 || last_pos !== exp_len) begin
            n_errors++; $display("FAIL %s_last count %0d pos %0d want 1/%0d", tag, last_cnt, last_pos, exp_len);
        end
        check_common(tag, exp_len);
    endtask

    task automatic test_abort_and_reset();
        bit to;
        begin_test();
        start_capture(1'b0, 0, 0);
        i_valid = 1'b1;
        repeat (6) begin i_data = NB_DATA'(ramp); tick(); ramp++; end
        i_abort = 1'b1; i_rd_en = 1'b1; i_start = 1'b1;
        tick();
        n_checks++;
        if ({o_busy, o_full, o_rd_valid} !== 3'b000 || o_trig_addr !== '0) begin
            n_errors++; $display("FAIL t5_abort busy/full/valid=%b trig=%0d want 000/0", {o_busy, o_full, o_rd_valid}, o_trig_addr);
        end
        idle_in();
        tick();
        ramp = 0;
        start_capture(1'b0, 0, 0);
        capture_ramp(100, to);
        i_rd_en = 1'b1;
        repeat (5) tick();
        i_reset = 1'b0;
        tick();
        n_checks++;
        if ({o_busy, o_full, o_rd_valid, o_rd_last} !== 4'b0000 || o_rd_data !== '0) begin
            n_errors++; $display("FAIL t5_reset flags=%b rd_data=%0d want 0000/0", {o_busy, o_full, o_rd_valid, o_rd_last}, o_rd_data);
        end
        n_checks++;
        if (got_q.size() !== 5 || to !== 1'b0) begin
            n_errors++; $display("FAIL t5_partial got %0d samples (timeout %b) want 5 (0)", got_q.size(), to);
        end
        i_reset = 1'b1; i_rd_en = 1'b0;
        tick();
        got_q.delete(); exp_q.delete(); ramp = 0;
        start_capture(1'b0, 0, 0);
        capture_ramp(100, to);
        read_n(16);
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== NB_DATA'(i)) begin n_errors++; $display("FAIL t5_data[%0d] got %0d want %0d", i, got_q[i], i); end
        end
        check_common("t5", 16);
    endtask

    task automatic test_rd_en_held();
        bit to;
        begin_test();
        i_rd_en = 1'b1;
        start_capture(1'b0, 1, 0);
        capture_ramp(200, to);
        n_checks++;
        if (to !== 1'b0) begin n_errors++; $display("FAIL t6_timeout full=%b want 1", o_full); end
        i_rd_en = 1'b1;
        repeat (20) tick();
        i_rd_en = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== NB_DATA'(2 * i)) begin n_errors++; $display("FAIL t6_data[%0d] got %0d want %0d", i, got_q[i], 2 * i); end
        end
        n_checks++;
        if (last_cnt !== 1 || last_pos !== 16) begin
            n_errors++; $display("FAIL t6_last count %0d pos %0d want 1/16", last_cnt, last_pos);
        end
        check_common("t6", 16);
    endtask

    task automatic test_random();
        int n, trig_at;
        bit mode;
        for (int it = 0; it < 10; it++) begin
            begin_test();
            mode    = 1'($urandom_range(0, 1));
            trig_at = $urandom_range(3, 60);
            start_capture(mode, $urandom_range(0, 3), $urandom_range(0, 15));
            n = 0;
            while (o_full !== 1'b1 && n < 600) begin
                i_valid = ($urandom_range(0, 3) != 0);
                i_data  = NB_DATA'($urandom);
                i_start = (n == trig_at);
                i_rd_en = 1'($urandom_range(0, 1));
                i_decim = NB_DECIM'($urandom_range(0, 15));
                i_mode  = 1'($urandom_range(0, 1));
                tick(); n++;
            end
            i_start = 1'b0;
            n_checks++;
            if (o_full !== 1'b1 && exp_q.size() == 0 && m_phase != PH_IDLE) begin
                n_errors++; $display("FAIL rnd%0d_timeout capture did not finish in 600 cycles", it);
            end
            n = 0;
            while (o_full === 1'b1 && n < 300) begin
                i_rd_en = 1'($urandom_range(0, 1));
                i_valid = 1'($urandom_range(0, 1));
                tick(); n++;
            end
            idle_in();
            repeat (2) tick();
            n_checks++;
            if (o_full !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_drain full=%b want 0", it, o_full); end
            check_common($sformatf("rnd%0d", it), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_decimation();
        test_pretrigger(30, 4, 16, 19, 14, "t3");
        test_pretrigger(5, 3, 9, 0, 5, "t4");
        test_abort_and_reset();
        test_rd_en_held();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
